// File: rtl/cache_controller_if.sv
// MEM-stage, cache and SRAM signal bundle for cache_controller.
// The controller connects through the slave view; the surrounding system drives the master view.
interface cache_controller_if #(
   parameter int unsigned CNT_W = 16
);
   logic [31:0]      address;
   logic [31:0]      wdata;
   logic             MEM_R_EN;
   logic             MEM_W_EN;
   logic [31:0]      rdata;
   logic             ready;
   logic [18:0]      cache_addr;
   logic             cache_R_EN;
   logic             cache_W_EN;
   logic             cache_invalidate;
   logic [63:0]      cache_wdata;
   logic             hit;
   logic [31:0]      cache_rdata;
   logic [31:0]      sram_address;
   logic [31:0]      sram_wdata;
   logic             sram_R_EN;
   logic             sram_W_EN;
   logic [63:0]      sram_rdata;
   logic             sram_ready;
   logic [CNT_W-1:0] hit_count;
   logic [CNT_W-1:0] miss_count;

   modport slave (
      input  address, wdata, MEM_R_EN, MEM_W_EN, hit, cache_rdata, sram_rdata, sram_ready,
      output rdata, ready, cache_addr, cache_R_EN, cache_W_EN, cache_invalidate, cache_wdata,
             sram_address, sram_wdata, sram_R_EN, sram_W_EN, hit_count, miss_count
   );

   modport master (
      output address, wdata, MEM_R_EN, MEM_W_EN, hit, cache_rdata, sram_rdata, sram_ready,
      input  rdata, ready, cache_addr, cache_R_EN, cache_W_EN, cache_invalidate, cache_wdata,
             sram_address, sram_wdata, sram_R_EN, sram_W_EN, hit_count, miss_count
   );
endinterface

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate controller between MEM stage, 2-way cache and SRAM.
// Hits complete in the request cycle; misses and stores hold ready low until sram_ready.
module cache_controller #(
   parameter logic [31:0] BASE_ADDR = 32'd1024,
   parameter int unsigned CNT_W     = 16
) (
   input logic               clk,
   input logic               rst,
   cache_controller_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_e;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_e           state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

   logic wr_req, rd_req;

   // A store wins when both enables are raised together.
   assign wr_req = bus.MEM_W_EN;
   assign rd_req = bus.MEM_R_EN & ~bus.MEM_W_EN;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      case (state_q)
         IDLE: begin
            if (wr_req) begin
               addr_d  = bus.address;
               wdata_d = bus.wdata;
               state_d = WR_THRU;
            end else if (rd_req && bus.hit) begin
               if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + CNT_ONE;
            end else if (rd_req) begin
               addr_d  = bus.address;
               state_d = RD_MISS;
               if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_ONE;
            end
         end
         RD_MISS: if (bus.sram_ready) state_d = IDLE;
         WR_THRU: if (bus.sram_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.ready            = 1'b1;
      bus.rdata            = '0;
      bus.cache_R_EN       = 1'b0;
      bus.cache_W_EN       = 1'b0;
      bus.cache_invalidate = 1'b0;
      bus.sram_R_EN        = 1'b0;
      bus.sram_W_EN        = 1'b0;
      case (state_q)
         IDLE: begin
            if (wr_req) begin
               bus.cache_invalidate = 1'b1;
               bus.ready            = 1'b0;
            end else if (rd_req && bus.hit) begin
               bus.cache_R_EN = 1'b1;
               bus.rdata      = bus.cache_rdata;
            end else if (rd_req) begin
               bus.ready = 1'b0;
            end
         end
         RD_MISS: begin
            bus.sram_R_EN = 1'b1;
            bus.ready     = 1'b0;
            if (bus.sram_ready) begin
               bus.cache_W_EN = 1'b1;
               bus.rdata      = addr_q[2] ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
               bus.ready      = 1'b1;
            end
         end
         WR_THRU: begin
            bus.sram_W_EN = 1'b1;
            bus.ready     = bus.sram_ready;
         end
         default: bus.ready = 1'b1;
      endcase
   end

   // Outside IDLE the latched request addresses the cache, not the live bus.
   assign bus.cache_addr   = ((state_q == IDLE) ? bus.address[18:0] : addr_q[18:0]) - BASE_ADDR[18:0];
   assign bus.cache_wdata  = bus.sram_rdata;
   assign bus.sram_address = addr_q - BASE_ADDR;
   assign bus.sram_wdata   = wdata_q;
   assign bus.hit_count    = hit_cnt_q;
   assign bus.miss_count   = miss_cnt_q;

endmodule
